sw_debounce_enc: RTL and testbench
==================================

SW_DEBOUNCE_ENC -- requirements
Module: sw_debounce_enc

Interface
REQ-001 Parameter N_SW, default 4: number of switch channels, range 1..15.
REQ-002 Parameter DB_CYCLES, default 20000: debounce stability window in clk_i cycles, minimum 2.
REQ-003 Parameter OUT_W, default 4: code width; 2^OUT_W-1 > N_SW, elaboration error otherwise.
REQ-004 clk_i  input  1  single system clock.
REQ-005 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-006 sw_i  input  N_SW  raw asynchronous switch levels, 1 = on.
REQ-007 sw_db_o  output  N_SW  debounced switch levels.
REQ-008 sw_o  output  OUT_W  registered encoded switch index.
REQ-009 valid_o  output  1  high when exactly one debounced switch is on.
REQ-010 chg_o  output  1  one-cycle pulse when sw_o changes value.

Function
REQ-011 Each sw_i bit SHALL pass through a 2-flop synchroniser before any other logic.
REQ-012 Each channel SHALL keep a stable bit and a counter of width clog2(DB_CYCLES).
REQ-013 Counter clears when sync == stable; increments while sync != stable.
REQ-014 Counter at DB_CYCLES-1 with sync != stable: stable <= sync, counter <= 0.
REQ-015 A glitch shorter than DB_CYCLES synchronised cycles SHALL clear the counter and leave stable unchanged.
REQ-016 Input step held steady: sw_db_o updates 2+DB_CYCLES edges after the step; sw_o/valid_o one edge later.
REQ-017 Encoding: exactly one bit k on -> sw_o = k+1, valid_o = 1.
REQ-018 Encoding: zero or multiple bits on -> valid_o = 0, sw_o = INVALID_CODE (all ones) unless REQ-026 applies.
REQ-019 chg_o SHALL be high for exactly the cycle in which the registered sw_o differs from its previous value.
REQ-020 chg_o SHALL never be high two consecutive cycles without a second sw_o change.
REQ-021 Channels SHALL debounce independently; simultaneous stable-updates on several channels SHALL be encoded together in one cycle.

Reset
REQ-022 rst_n_i low SHALL asynchronously clear synchronisers, stable bits, and counters to 0.
REQ-023 During reset: sw_db_o = 0, sw_o = INVALID_CODE, valid_o = 0, chg_o = 0.
REQ-024 Reset mid-debounce SHALL discard partial counts; no chg_o on the first cycle after release.
REQ-025 Switches already on at reset release SHALL be accepted via the normal REQ-016 latency.

Configuration
REQ-026 Macro SW_HOLD_LAST_EN defined: on zero/multiple switches on, sw_o holds last valid code and valid_o = 0; no chg_o is raised for that transition.
REQ-027 Macro SW_HOLD_LAST_EN undefined: REQ-018 behaviour, sw_o = INVALID_CODE with chg_o pulse if the value changed.

Structure
REQ-028 Package sw_pkg SHALL hold INVALID_CODE derivation, the code-width check function, and the default DB_CYCLES constant.
REQ-029 Sub-module sw_db_ch SHALL implement one channel (synchroniser, counter, stable bit), instantiated N_SW times by generate.
REQ-030 Encoder and chg_o logic SHALL live in sw_debounce_enc.

Verification (N_SW=4, DB_CYCLES=4, OUT_W=4)
REQ-031 Reset release, sw_i=0000 -> sw_o=1111, valid_o=0, chg_o never high.
REQ-032 sw_i 0000->0100 held -> sw_db_o=0100 after 6 edges, sw_o=0011, valid_o=1, single chg_o pulse on edge 7.
REQ-033 3-cycle pulse on sw_i[0] -> sw_db_o, sw_o, chg_o unchanged.
REQ-034 sw_i 0001->1001 held -> sw_o=1111, valid_o=0, chg_o pulse (macro off); sw_o=0001 held, no pulse (macro on).
REQ-035 rst_n_i asserted at count 2 of a debounce -> outputs reset immediately; after release with input held, update takes the full 6 edges.
REQ-036 sw_i 0010->1000 same edge -> sw_o 0010->0100 directly in one cycle, one chg_o pulse.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared constants and elaboration-time helpers for the switch debouncer/encoder.
// The code-hold behaviour is selected with the SW_HOLD_LAST_EN macro in sw_debounce_enc.
package sw_pkg;

    localparam int DB_CYCLES_DEFAULT = 20000;

    // All-ones code marks "no single switch on".
    function automatic int invalid_code(input int out_w);
        return (1 << out_w) - 1;
    endfunction

    // Codes 1..N_SW must all fit below the all-ones reserved code.
    function automatic bit code_width_ok(input int n_sw, input int out_w);
        return ((1 << out_w) - 1) > n_sw;
    endfunction

endpackage

// File: rtl/sw_db_ch.sv
// One switch channel: 2-flop synchroniser, stability counter and debounced level.
module sw_db_ch
    import sw_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sw_i,
    output logic db_o
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronised level agrees with stable restarts the window.
    always_comb begin
        sync1_d  = sw_i;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign db_o = stable_q;

endmodule

// File: rtl/sw_debounce_enc.sv
// Debounces N_SW switches and encodes the single active one as index+1.
// Define SW_HOLD_LAST_EN to keep the last valid code when zero/multiple switches are on.
module sw_debounce_enc
    import sw_pkg::*;
#(
    parameter int N_SW      = 4,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int OUT_W     = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_SW-1:0]  sw_i,
    output logic [N_SW-1:0]  sw_db_o,
    output logic [OUT_W-1:0] sw_o,
    output logic             valid_o,
    output logic             chg_o
);

    localparam logic [OUT_W-1:0] INVALID_CODE = OUT_W'(invalid_code(OUT_W));

    if (!code_width_ok(N_SW, OUT_W)) begin : g_bad_out_w
        $error("sw_debounce_enc: OUT_W too narrow for N_SW");
    end
    if (N_SW < 1 || N_SW > 15) begin : g_bad_n_sw
        $error("sw_debounce_enc: N_SW out of range 1..15");
    end
    if (DB_CYCLES < 2) begin : g_bad_db
        $error("sw_debounce_enc: DB_CYCLES must be at least 2");
    end

    logic [N_SW-1:0] sw_db;

    for (genvar k = 0; k < N_SW; k++) begin : g_ch
        sw_db_ch #(
            .DB_CYCLES(DB_CYCLES)
        ) u_ch (
            .clk_i  (clk_i),
            .rst_n_i(rst_n_i),
            .sw_i   (sw_i[k]),
            .db_o   (sw_db[k])
        );
    end

    logic             hit;
    logic             multi;
    logic [OUT_W-1:0] idx;
    logic [OUT_W-1:0] sw_q, sw_d;
    logic             valid_q, valid_d;
    logic             chg_q, chg_d;

    always_comb begin
        hit   = 1'b0;
        multi = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_SW; k++) begin
            if (sw_db[k]) begin
                multi = multi | hit;
                hit   = 1'b1;
                idx   = OUT_W'(k + 1);
            end
        end
    end

    always_comb begin
        valid_d = hit & ~multi;
`ifdef SW_HOLD_LAST_EN
        sw_d = valid_d ? idx : sw_q;
`else
        sw_d = valid_d ? idx : INVALID_CODE;
`endif
        chg_d = (sw_d != sw_q);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sw_q    <= INVALID_CODE;
            valid_q <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            sw_q    <= sw_d;
            valid_q <= valid_d;
            chg_q   <= chg_d;
        end
    end

    assign sw_db_o = sw_db;
    assign sw_o    = sw_q;
    assign valid_o = valid_q;
    assign chg_o   = chg_q;

endmodule

// File: tb/tb_sw_debounce_enc.sv
// Self-checking bench for sw_debounce_enc (N_SW=4, DB_CYCLES=4, OUT_W=4).
// Honours SW_HOLD_LAST_EN when the same macro is defined for the build.
module tb_sw_debounce_enc;

    localparam int N_SW = 4;
    localparam int DB   = 4;
    localparam int OW   = 4;
`ifdef SW_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic [N_SW-1:0] sw_i;
    logic [N_SW-1:0] sw_db_o;
    logic [OW-1:0]   sw_o;
    logic            valid_o;
    logic            chg_o;

    sw_debounce_enc #(
        .N_SW(N_SW), .DB_CYCLES(DB), .OUT_W(OW)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .sw_i   (sw_i),
        .sw_db_o(sw_db_o),
        .sw_o   (sw_o),
        .valid_o(valid_o),
        .chg_o  (chg_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int chg_seen = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: stable flips when the last DB synchronised samples all disagree
    logic [N_SW-1:0] m_stable;
    logic [OW-1:0]   m_code;
    logic            m_valid;
    logic            m_chg;
    logic [N_SW-1:0] in_q[$];
    logic [N_SW-1:0] syn_q[$];

    task automatic model_reset();
        m_stable = '0;
        m_code   = '1;
        m_valid  = 1'b0;
        m_chg    = 1'b0;
        in_q.delete();
        syn_q.delete();
        in_q.push_back('0);
        in_q.push_back('0);
    endtask

    task automatic model_edge(input logic [N_SW-1:0] cur);
        logic [N_SW-1:0] s;
        logic [N_SW-1:0] nstable;
        logic [OW-1:0]   ncode;
        logic            nvalid;
        bit              all_diff;
        s = in_q[in_q.size() - 2];
        in_q.push_back(cur);
        if (in_q.size() > 4) void'(in_q.pop_front());
        syn_q.push_back(s);
        if (syn_q.size() > DB) void'(syn_q.pop_front());

        nvalid = ($countones(m_stable) == 1);
        if (nvalid) ncode = OW'($clog2(m_stable) + 1);
        else if (HOLD) ncode = m_code;
        else ncode = '1;
        m_chg   = (ncode != m_code);
        m_code  = ncode;
        m_valid = nvalid;

        nstable = m_stable;
        if (syn_q.size() == DB) begin
            for (int k = 0; k < N_SW; k++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DB; j++)
                    if (syn_q[j][k] == m_stable[k]) all_diff = 1'b0;
                if (all_diff) nstable[k] = ~m_stable[k];
            end
        end
        m_stable = nstable;
    endtask

    // driver: one clock edge, then compare every output with the model
    task automatic step();
        logic [N_SW-1:0] cur;
        cur = sw_i;
        @(posedge clk);
        #1;
        model_edge(cur);
        check("sw_db_o", 8'(sw_db_o), 8'(m_stable));
        check("sw_o", 8'(sw_o), 8'(m_code));
        check("valid_o", 8'(valid_o), 8'(m_valid));
        check("chg_o", 8'(chg_o), 8'(m_chg));
        if (chg_o) chg_seen++;
    endtask

    typedef struct {
        logic [N_SW-1:0] sw;
        int              cycles;
        logic [N_SW-1:0] exp_db;
        logic [OW-1:0]   exp_sw;
        logic            exp_valid;
        int              exp_chg;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{4'b0001, 10, 4'b0001, 4'h1, 1'b1, 1};
        vecs[1] = '{4'b1001, 10, 4'b1001, HOLD ? 4'h1 : 4'hF, 1'b0, HOLD ? 0 : 1};
        vecs[2] = '{4'b0010, 10, 4'b0010, 4'h2, 1'b1, 1};
        vecs[3] = '{4'b0000, 10, 4'b0000, HOLD ? 4'h2 : 4'hF, 1'b0, HOLD ? 0 : 1};
        vecs[4] = '{4'b1000, 10, 4'b1000, 4'h4, 1'b1, 1};
        vecs[5] = '{4'b1111, 10, 4'b1111, HOLD ? 4'h4 : 4'hF, 1'b0, HOLD ? 0 : 1};
        vecs[6] = '{4'b0110, 10, 4'b0110, HOLD ? 4'h4 : 4'hF, 1'b0, 0};
        vecs[7] = '{4'b0010, 10, 4'b0010, 4'h2, 1'b1, 1};

        rst_n = 1'b0;
        sw_i  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset sw_db_o", 8'(sw_db_o), 8'h0);
        check("reset sw_o", 8'(sw_o), 8'hF);
        check("reset valid_o", 8'(valid_o), 8'h0);
        check("reset chg_o", 8'(chg_o), 8'h0);
        rst_n = 1'b1;

        // idle after reset: no pulses, invalid code
        chg_seen = 0;
        repeat (10) step();
        check("idle sw_o", 8'(sw_o), 8'hF);
        check("idle chg count", 8'(chg_seen), 8'd0);

        // single step: exact latency of debounce and encode
        sw_i = 4'b0100;
        chg_seen = 0;
        repeat (5) step();
        check("step db edge5", 8'(sw_db_o), 8'h0);
        step();
        check("step db edge6", 8'(sw_db_o), 8'h4);
        check("step sw_o edge6", 8'(sw_o), 8'hF);
        step();
        check("step sw_o edge7", 8'(sw_o), 8'h3);
        check("step valid edge7", 8'(valid_o), 8'h1);
        check("step chg edge7", 8'(chg_o), 8'h1);
        step();
        check("step chg edge8", 8'(chg_o), 8'h0);
        check("step chg count", 8'(chg_seen), 8'd1);

        // 3-cycle glitch on channel 0 must be rejected
        chg_seen = 0;
        sw_i = 4'b0101;
        repeat (3) step();
        sw_i = 4'b0100;
        repeat (10) begin
            step();
            check("glitch db", 8'(sw_db_o), 8'h4);
            check("glitch sw_o", 8'(sw_o), 8'h3);
        end
        check("glitch chg count", 8'(chg_seen), 8'd0);

        // table-driven settled patterns
        for (int v = 0; v < 8; v++) begin
            sw_i = vecs[v].sw;
            chg_seen = 0;
            repeat (vecs[v].cycles) step();
            check($sformatf("vec%0d db", v), 8'(sw_db_o), 8'(vecs[v].exp_db));
            check($sformatf("vec%0d sw_o", v), 8'(sw_o), 8'(vecs[v].exp_sw));
            check($sformatf("vec%0d valid", v), 8'(valid_o), 8'(vecs[v].exp_valid));
            check($sformatf("vec%0d chg count", v), 8'(chg_seen), 8'(vecs[v].exp_chg));
        end

        // two channels swap on the same edge: direct 2 -> 4
        sw_i = 4'b1000;
        chg_seen = 0;
        repeat (10) begin
            step();
            n_checks++;
            if (sw_o != 4'h2 && sw_o != 4'h4) begin
                n_fails++;
                $display("FAIL swap sw_o: got %0h expected 2 or 4", sw_o);
            end
        end
        check("swap sw_o", 8'(sw_o), 8'h4);
        check("swap chg count", 8'(chg_seen), 8'd1);

        // reset in the middle of a debounce
        sw_i = 4'b0100;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("midrst db", 8'(sw_db_o), 8'h0);
        check("midrst sw_o", 8'(sw_o), 8'hF);
        check("midrst valid", 8'(valid_o), 8'h0);
        check("midrst chg", 8'(chg_o), 8'h0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst held sw_o", 8'(sw_o), 8'hF);
        rst_n = 1'b1;
        model_reset();
        chg_seen = 0;
        step();
        check("postrst chg edge1", 8'(chg_o), 8'h0);
        repeat (4) step();
        check("postrst db edge5", 8'(sw_db_o), 8'h0);
        step();
        check("postrst db edge6", 8'(sw_db_o), 8'h4);
        step();
        check("postrst sw_o edge7", 8'(sw_o), 8'h3);
        check("postrst chg count", 8'(chg_seen), 8'd1);

        // randomized levels and hold times against the model
        for (int i = 0; i < 300; i++) begin
            sw_i = N_SW'($urandom_range(0, 15));
            repeat ($urandom_range(1, 8)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
